// File: rtl/gfx256_attr_interp.sv
// Two-stage barycentric interpolator: NUM_ATTR unsigned channels, signed depth.
// Build option: GFX256_INTERP_ROUND_EN enables round-half-up before the shift.
module gfx256_attr_interp #(
  parameter int POINT_WIDTH = 16,
  parameter int NUM_ATTR    = 4,
  parameter int ATTR_WIDTH  = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  input  logic        [POINT_WIDTH-1:0]        factor0_i,
  input  logic        [POINT_WIDTH-1:0]        factor1_i,
  input  logic        [POINT_WIDTH-1:0]        x_i,
  input  logic        [POINT_WIDTH-1:0]        y_i,
  input  logic        [NUM_ATTR*ATTR_WIDTH-1:0] attr0_i,
  input  logic        [NUM_ATTR*ATTR_WIDTH-1:0] attr1_i,
  input  logic        [NUM_ATTR*ATTR_WIDTH-1:0] attr2_i,
  input  logic signed [POINT_WIDTH-1:0]        z0_i,
  input  logic signed [POINT_WIDTH-1:0]        z1_i,
  input  logic signed [POINT_WIDTH-1:0]        z2_i,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic        [NUM_ATTR*ATTR_WIDTH-1:0] attr_o,
  output logic signed [POINT_WIDTH-1:0]        z_o,
  output logic        [POINT_WIDTH-1:0]        x_o,
  output logic        [POINT_WIDTH-1:0]        y_o,
  output logic        [POINT_WIDTH-1:0]        bezier_factor0_o,
  output logic        [POINT_WIDTH-1:0]        bezier_factor1_o
);

  localparam int PW = POINT_WIDTH;
  localparam int AW = ATTR_WIDTH;
  localparam int CW = NUM_ATTR * ATTR_WIDTH;
  localparam int FW = PW + 1;
  localparam int SW = AW + PW + 2;
  localparam int DW = 2 * PW + 4;

`ifdef GFX256_INTERP_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  localparam logic [SW-1:0] RND_A =
    ROUND ? (SW'(1) << (PW - 1)) : '0;
  localparam logic signed [DW-1:0] RND_Z =
    ROUND ? (DW'(1) <<< (PW - 1)) : '0;
  localparam logic signed [DW-1:0] ZMAX =
    DW'((2 ** (PW - 1)) - 1);
  localparam logic signed [DW-1:0] ZMIN = ~ZMAX;

  logic                 s1_valid;
  logic                 s2_valid;
  logic                 s2_ready;
  logic                 accept;
  logic                 advance;
  logic        [FW-1:0] s1_f0;
  logic        [FW-1:0] s1_f1;
  logic        [FW-1:0] s1_f2;
  logic        [CW-1:0] s1_a0;
  logic        [CW-1:0] s1_a1;
  logic        [CW-1:0] s1_a2;
  logic signed [PW-1:0] s1_z0;
  logic signed [PW-1:0] s1_z1;
  logic signed [PW-1:0] s1_z2;
  logic        [PW-1:0] s1_x;
  logic        [PW-1:0] s1_y;
  logic        [FW-1:0] fsum;
  logic        [FW-1:0] f2_n;

  assign s2_ready = !s2_valid || ready_i;
  assign ready_o  = !s1_valid || s2_ready;
  assign accept   = valid_i && ready_o;
  assign advance  = s1_valid && s2_ready;
  assign valid_o  = s2_valid;

  // Third weight is whatever remains of 1.0; overweight pairs give zero.
  assign fsum = {1'b0, factor0_i} + {1'b0, factor1_i};
  assign f2_n = fsum[PW] ? '0 : (FW'(1) << PW) - fsum;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_f0    <= '0;
      s1_f1    <= '0;
      s1_f2    <= '0;
      s1_a0    <= '0;
      s1_a1    <= '0;
      s1_a2    <= '0;
      s1_z0    <= '0;
      s1_z1    <= '0;
      s1_z2    <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_f0    <= {1'b0, factor0_i};
      s1_f1    <= {1'b0, factor1_i};
      s1_f2    <= f2_n;
      s1_a0    <= attr0_i;
      s1_a1    <= attr1_i;
      s1_a2    <= attr2_i;
      s1_z0    <= z0_i;
      s1_z1    <= z1_i;
      s1_z2    <= z2_i;
      s1_x     <= x_i;
      s1_y     <= y_i;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  logic        [SW-1:0]   acc;
  logic        [AW+1:0]   res;
  logic        [CW-1:0]   attr_n;
  logic signed [DW-1:0]   zacc;
  logic signed [DW-1:0]   zsh;
  logic signed [PW-1:0]   z_n;
  logic        [PW-1:0]   bez0_n;

  always_comb begin
    attr_n = '0;
    acc    = '0;
    res    = '0;
    for (int k = 0; k < NUM_ATTR; k++) begin
      acc = SW'(s1_f0) * SW'(s1_a0[k*AW +: AW])
          + SW'(s1_f1) * SW'(s1_a1[k*AW +: AW])
          + SW'(s1_f2) * SW'(s1_a2[k*AW +: AW])
          + RND_A;
      res = (AW + 2)'(acc >> PW);
      attr_n[k*AW +: AW] = (|res[AW+1:AW]) ? '1 : res[AW-1:0];
    end
  end

  always_comb begin
    zacc = DW'($signed({1'b0, s1_f0})) * DW'(s1_z0)
         + DW'($signed({1'b0, s1_f1})) * DW'(s1_z1)
         + DW'($signed({1'b0, s1_f2})) * DW'(s1_z2)
         + RND_Z;
    zsh  = zacc >>> PW;
    z_n  = zsh[PW-1:0];
    if (zsh > ZMAX) begin
      z_n = ZMAX[PW-1:0];
    end else if (zsh < ZMIN) begin
      z_n = ZMIN[PW-1:0];
    end
  end

  // f1 < 2^PW, so the halved term always fits before the add wraps.
  assign bez0_n = PW'(s1_f1 >> 1) + s1_f2[PW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid         <= 1'b0;
      attr_o           <= '0;
      z_o              <= '0;
      x_o              <= '0;
      y_o              <= '0;
      bezier_factor0_o <= '0;
      bezier_factor1_o <= '0;
    end else if (advance) begin
      s2_valid         <= 1'b1;
      attr_o           <= attr_n;
      z_o              <= z_n;
      x_o              <= s1_x;
      y_o              <= s1_y;
      bezier_factor0_o <= bez0_n;
      bezier_factor1_o <= s1_f2[PW-1:0];
    end else if (ready_i) begin
      s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gfx256_attr_interp.sv
// Bench for gfx256_attr_interp: fixed vectors, stall/reset sequences, random stream.
// Honours GFX256_INTERP_ROUND_EN for expected rounding results.
module tb_gfx256_attr_interp;

  localparam int PW = 16;
  localparam int NA = 4;
  localparam int AW = 16;
  localparam int CW = NA * AW;
  localparam longint ONE  = longint'(1) << PW;
  localparam longint MAXA = (longint'(1) << AW) - 1;
  localparam longint ZHI  = (longint'(1) << (PW - 1)) - 1;
  localparam longint ZLO  = -(longint'(1) << (PW - 1));
`ifdef GFX256_INTERP_ROUND_EN
  localparam longint RND = longint'(1) << (PW - 1);
  localparam int RA = 1;
`else
  localparam longint RND = 0;
  localparam int RA = 0;
`endif

  typedef struct packed {
    logic        [PW-1:0] f0;
    logic        [PW-1:0] f1;
    logic        [PW-1:0] x;
    logic        [PW-1:0] y;
    logic        [CW-1:0] a0;
    logic        [CW-1:0] a1;
    logic        [CW-1:0] a2;
    logic signed [PW-1:0] z0;
    logic signed [PW-1:0] z1;
    logic signed [PW-1:0] z2;
  } pix_t;

  typedef struct packed {
    logic [CW-1:0] attr;
    logic [PW-1:0] z;
    logic [PW-1:0] x;
    logic [PW-1:0] y;
    logic [PW-1:0] b0;
    logic [PW-1:0] b1;
  } out_t;

  typedef struct {
    string name;
    pix_t  p;
    out_t  e;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 valid_i;
  logic                 ready_o;
  logic                 valid_o;
  logic                 ready_i;
  pix_t                 pin;
  logic        [CW-1:0] attr_o;
  logic signed [PW-1:0] z_o;
  logic        [PW-1:0] x_o;
  logic        [PW-1:0] y_o;
  logic        [PW-1:0] b0_o;
  logic        [PW-1:0] b1_o;

  always #5 clk = ~clk;

  gfx256_attr_interp #(
    .POINT_WIDTH(PW),
    .NUM_ATTR   (NA),
    .ATTR_WIDTH (AW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .factor0_i       (pin.f0),
    .factor1_i       (pin.f1),
    .x_i             (pin.x),
    .y_i             (pin.y),
    .attr0_i         (pin.a0),
    .attr1_i         (pin.a1),
    .attr2_i         (pin.a2),
    .z0_i            (pin.z0),
    .z1_i            (pin.z1),
    .z2_i            (pin.z2),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .attr_o          (attr_o),
    .z_o             (z_o),
    .x_o             (x_o),
    .y_o             (y_o),
    .bezier_factor0_o(b0_o),
    .bezier_factor1_o(b1_o)
  );

  int   total = 0;
  int   bad = 0;
  bit   sb_en = 0;
  bit   stall_prev = 0;
  out_t held;
  out_t q[$];
  vec_t tbl[6];

  task automatic check(string name, bit ok, string detail);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic out_t dut_out();
    out_t o;
    o.attr = attr_o;
    o.z    = z_o;
    o.x    = x_o;
    o.y    = y_o;
    o.b0   = b0_o;
    o.b1   = b1_o;
    return o;
  endfunction

  function automatic string fo(out_t o);
    return $sformatf("attr=%h z=%0d x=%h y=%h b0=%h b1=%h",
                     o.attr, $signed(o.z), o.x, o.y, o.b0, o.b1);
  endfunction

  // Reference: weights as integers, 1.0 == 2^PW, floor division by 2^PW.
  function automatic out_t model(pix_t p);
    out_t   o;
    longint f0, f1, f2, s, acc, r;
    f0 = longint'(p.f0);
    f1 = longint'(p.f1);
    s  = f0 + f1;
    f2 = (s >= ONE) ? 0 : ONE - s;
    o  = '0;
    for (int k = 0; k < NA; k++) begin
      acc = f0 * longint'(p.a0[k*AW +: AW])
          + f1 * longint'(p.a1[k*AW +: AW])
          + f2 * longint'(p.a2[k*AW +: AW]) + RND;
      r = acc / ONE;
      if (r > MAXA) r = MAXA;
      o.attr[k*AW +: AW] = r[AW-1:0];
    end
    acc = f0 * longint'($signed(p.z0)) + f1 * longint'($signed(p.z1))
        + f2 * longint'($signed(p.z2)) + RND;
    r = acc >>> PW;
    if (r > ZHI) r = ZHI;
    if (r < ZLO) r = ZLO;
    o.z  = r[PW-1:0];
    o.x  = p.x;
    o.y  = p.y;
    r    = (f1 / 2) + f2;
    o.b0 = r[PW-1:0];
    o.b1 = f2[PW-1:0];
    return o;
  endfunction

  function automatic vec_t mk(string n, int f0, int f1,
                              int a0, int a1, int a2,
                              int z0, int z1, int z2,
                              int ea, int ez, int eb0, int eb1);
    vec_t v;
    v.name   = n;
    v.p.f0   = PW'(f0);
    v.p.f1   = PW'(f1);
    v.p.x    = PW'(f0 ^ 'h1357);
    v.p.y    = PW'(f1 + 'h2468);
    v.p.a0   = {NA{AW'(a0)}};
    v.p.a1   = {NA{AW'(a1)}};
    v.p.a2   = {NA{AW'(a2)}};
    v.p.z0   = PW'(z0);
    v.p.z1   = PW'(z1);
    v.p.z2   = PW'(z2);
    v.e.attr = {NA{AW'(ea)}};
    v.e.z    = PW'(ez);
    v.e.x    = v.p.x;
    v.e.y    = v.p.y;
    v.e.b0   = PW'(eb0);
    v.e.b1   = PW'(eb1);
    return v;
  endfunction

  function automatic logic [PW-1:0] pick_f();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return PW'(ONE >> 1);
      default: return PW'($urandom);
    endcase
  endfunction

  function automatic pix_t rnd_pix();
    pix_t p;
    p.f0 = pick_f();
    p.f1 = pick_f();
    p.x  = PW'($urandom);
    p.y  = PW'($urandom);
    for (int k = 0; k < NA; k++) begin
      p.a0[k*AW +: AW] = ($urandom_range(0, 5) == 0) ? '1 : AW'($urandom);
      p.a1[k*AW +: AW] = ($urandom_range(0, 5) == 0) ? '1 : AW'($urandom);
      p.a2[k*AW +: AW] = AW'($urandom);
    end
    p.z0 = ($urandom_range(0, 5) == 0) ? PW'(ZLO) : PW'($urandom);
    p.z1 = ($urandom_range(0, 5) == 0) ? PW'(ZHI) : PW'($urandom);
    p.z2 = PW'($urandom);
    return p;
  endfunction

  // Scoreboard; queue depth equals pixels currently inside the block.
  always @(negedge clk) begin
    if (!rst_n || !sb_en) begin
      stall_prev = 0;
    end else begin
      check("ready_o", ready_o == !(q.size() == 2 && !ready_i),
            $sformatf("ready_o=%b want %b (inflight=%0d ready_i=%b)",
                      ready_o, !(q.size() == 2 && !ready_i),
                      q.size(), ready_i));
      if (stall_prev)
        check("hold", valid_o && dut_out() == held,
              $sformatf("valid_o=%b %s want 1 %s",
                        valid_o, fo(dut_out()), fo(held)));
      stall_prev = valid_o && !ready_i;
      held = dut_out();
      if (valid_o && ready_i) begin
        if (q.size() == 0) begin
          check("extra_out", 1'b0, $sformatf("got %s want none",
                                             fo(dut_out())));
        end else begin
          out_t e;
          e = q.pop_front();
          check("data", dut_out() == e,
                $sformatf("got %s want %s", fo(dut_out()), fo(e)));
        end
      end
      if (valid_i && ready_o) q.push_back(model(pin));
    end
  end

  task automatic apply_vec(vec_t v);
    @(posedge clk); #1;
    ready_i = 1'b1;
    pin     = v.p;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    check({v.name, "_lat1"}, valid_o == 1'b0,
          $sformatf("valid_o=%b want 0", valid_o));
    @(posedge clk); #1;
    check({v.name, "_lat2"}, valid_o && dut_out() == v.e,
          $sformatf("valid_o=%b %s want 1 %s",
                    valid_o, fo(dut_out()), fo(v.e)));
  endtask

  task automatic stream(int n, bit rnd, int lo, int hi);
    pix_t p;
    int   idx;
    int   cyc;
    p   = rnd_pix();
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 30000) begin
      @(posedge clk); #1;
      ready_i = rnd ? ($urandom_range(0, 3) != 0)
                    : !(cyc >= lo && cyc <= hi);
      valid_i = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
      pin     = p;
      @(negedge clk);
      if (valid_i && ready_o) begin
        idx++;
        p = rnd_pix();
      end
      cyc++;
    end
    check("stream_sent", idx == n,
          $sformatf("sent=%0d want %0d", idx, n));
    @(posedge clk); #1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain", q.size() == 0,
          $sformatf("left=%0d want 0", q.size()));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk("basic", 'h8000, 'h4000, 100, 200, 300,
                -100, 0, 100, 175, -25, 'h6000, 'h4000);
    tbl[1] = mk("zero_w", 0, 0, 5, 6, 1234,
                7, 8, -9, 1234, -9, 0, 0);
    tbl[2] = mk("sat_hi", 'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF, 0,
                32767, 32767, 0, 'hFFFF, 32767, 'h7FFF, 0);
    tbl[3] = mk("sat_lo", 'hFFFF, 'hFFFF, 0, 0, 0,
                -32768, -32768, 0, 0, -32768, 'h7FFF, 0);
    tbl[4] = mk("round", 'h5555, 'h5555, 1, 1, 0,
                0, 0, 0, RA, 0, 'h8000, 'h5556);
    tbl[5] = mk("mid", 'h4000, 'h4000, 1000, 2000, 3000,
                400, -800, 1200, 2250, 500, 'hA000, 'h8000);

    rst_n   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    pin     = '0;
    #12;
    check("reset_state",
          !valid_o && ready_o && dut_out() == '0,
          $sformatf("valid_o=%b ready_o=%b %s want 0 1 zeros",
                    valid_o, ready_o, fo(dut_out())));
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) apply_vec(tbl[i]);
    @(posedge clk); #1;
    check("empty_after_tbl", !valid_o && ready_o,
          $sformatf("valid_o=%b ready_o=%b want 0 1",
                    valid_o, ready_o));

    sb_en = 1;
    stream(8, 1'b0, 3, 6);
    stream(3000, 1'b1, 0, 0);

    // Fill both stages, then reset asynchronously between edges.
    @(posedge clk); #1;
    ready_i = 1'b0;
    pin     = tbl[2].p;
    valid_i = 1'b1;
    @(posedge clk); #1;
    pin     = tbl[3].p;
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("full_stall", valid_o && !ready_o,
          $sformatf("valid_o=%b ready_o=%b want 1 0", valid_o, ready_o));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async",
          !valid_o && ready_o && dut_out() == '0,
          $sformatf("valid_o=%b ready_o=%b %s want 0 1 zeros",
                    valid_o, ready_o, fo(dut_out())));
    sb_en = 0;
    q.delete();
    ready_i = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_empty", !valid_o && ready_o,
          $sformatf("valid_o=%b ready_o=%b want 0 1", valid_o, ready_o));
    apply_vec(tbl[5]);
    @(posedge clk); #1;
    check("post_rst_drain", !valid_o,
          $sformatf("valid_o=%b want 0", valid_o));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
